forward_unit_alu: RTL and testbench
===================================

Name: forward_unit_alu

Overview:
- Operand-forwarding stage for the scalar ALU path of the ASIP pipeline.
- Takes the two register-file operands read in stage 3 (R2res3, R3res3) and their source register indices (R2_2, R3_2).
- Replaces each operand with a newer in-flight result when a hazard exists:
  - stage-3 result (DestR_3/Res), or
  - stage-4 result (DestR_4/Res1).
- Registers the selected operands into the stage-4 operand outputs (R2res4, R3res4).

Parameters:
- DATA_W, 32, operand/result width in bits
- REG_W, 4, register index width (16 architectural registers)

Ports:
- clk  input  1  pipeline clock, rising-edge active
- rst  input  1  asynchronous active-low reset
- R2res3  input  DATA_W  operand A read from the register file
- R3res3  input  DATA_W  operand B read from the register file (or immediate path value)
- R2_2  input  REG_W  source register index of operand A
- R3_2  input  REG_W  source register index of operand B
- ExtndSel1  input  2  immediate extension mode of the current instruction
- immF  input  1  1 = operand B is an immediate, not a register
- DestR_3  input  REG_W  destination register of the instruction one stage ahead
- Res  input  DATA_W  result of the instruction one stage ahead
- DestR_4  input  REG_W  destination register of the instruction two stages ahead
- Res1  input  DATA_W  result of the instruction two stages ahead
- R2res4  output  DATA_W  forwarded operand A, registered
- R3res4  output  DATA_W  forwarded operand B, registered

Behaviour:
- One clock domain. Reset is asynchronous and active-low:
  - rst=0 immediately forces R2res4=0 and R3res4=0.
  - Outputs hold 0 while rst=0.
  - The first capture occurs on the first rising clk edge after rst returns to 1.
- Selection logic is purely combinational from the current inputs. Outputs are captured on each rising clk edge, giving 1-cycle latency from inputs to R2res4/R3res4. There is no stall or enable; a capture happens every cycle.
- Operand A next value, in priority order:
  1. R2_2 == DestR_3 -> Res
  2. else R2_2 == DestR_4 -> Res1
  3. else R2res3
- Operand B next value:
  - immF=1 -> R3res3 unconditionally. No forwarding, even if R3_2 matches DestR_3 or DestR_4.
  - immF=0 -> same priority as operand A, using R3_2:
    1. R3_2 == DestR_3 -> Res
    2. else R3_2 == DestR_4 -> Res1
    3. else R3res3
- Both stages matching: stage 3 (Res) wins, because it is the youngest producer.
- A and B matching the same destination: both receive the same forwarded value independently.
- All 16 register indices, including 0, are forwardable. There are no write-enable qualifiers; a destination index is always treated as valid.
- ExtndSel1 does not influence either selection. It is accepted for interface compatibility with the decode stage and is otherwise ignored. immF alone controls B-suppression.
- Data is passed bit-exact, with no arithmetic and no width change.
- Reset asserted mid-operation: outputs clear asynchronously and any pending capture is discarded.

Test Plan:
1. Stage-3 priority on A: immF=0, R2res3=0x10, R3res3=0x564, R2_2=5, R3_2=6, ExtndSel1=0, DestR_3=5, Res=0x15, DestR_4=5, Res1=0x16; one clk -> R2res4=0x15, R3res4=0x564.
2. Stage-4 forward on A: as in 1 but DestR_3=4; one clk -> R2res4=0x16, R3res4=0x564.
3. Stage-3 priority on B: immF=0, R2res3=0x10, R3res3=0x11, R2_2=5, R3_2=6, DestR_3=6, Res=0x15, DestR_4=6, Res1=0x16; one clk -> R3res4=0x15, R2res4=0x10.
4. Immediate suppresses B: as in 3 but immF=1, ExtndSel1=2'b10; one clk -> R3res4=0x11, R2res4=0x10.
5. No hazard and double match: R2_2=R3_2=7, DestR_3=2, DestR_4=3 -> outputs equal R2res3/R3res3. Then DestR_3=7, immF=0 -> both outputs = Res.
6. Reset: load case 1 and clock, then drive rst=0 between edges -> outputs become 0 without a clk edge. Release rst -> next edge captures the current selection.

Source files
------------

// File: rtl/forward_unit_alu.sv
// Operand-forwarding stage for the scalar ALU path: picks the youngest in-flight
// producer for each source operand and registers the result into stage 4.
module forward_unit_alu #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] R2res3,
  input  logic [DATA_W-1:0] R3res3,
  input  logic [REG_W-1:0]  R2_2,
  input  logic [REG_W-1:0]  R3_2,
  input  logic [1:0]        ExtndSel1,
  input  logic              immF,
  input  logic [REG_W-1:0]  DestR_3,
  input  logic [DATA_W-1:0] Res,
  input  logic [REG_W-1:0]  DestR_4,
  input  logic [DATA_W-1:0] Res1,
  output logic [DATA_W-1:0] R2res4,
  output logic [DATA_W-1:0] R3res4
);

  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] b_next;

  // Extension mode is carried for decode-stage compatibility only.
  logic ext_sel_unused;
  assign ext_sel_unused = ^ExtndSel1;

  // Stage 3 is checked first: it holds the youngest producer.
  always_comb begin
    a_next = R2res3;
    if (R2_2 == DestR_3) begin
      a_next = Res;
    end else if (R2_2 == DestR_4) begin
      a_next = Res1;
    end
  end

  always_comb begin
    b_next = R3res3;
    if (!immF) begin
      if (R3_2 == DestR_3) begin
        b_next = Res;
      end else if (R3_2 == DestR_4) begin
        b_next = Res1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      R2res4 <= '0;
      R3res4 <= '0;
    end else begin
      R2res4 <= a_next;
      R3res4 <= b_next;
    end
  end

endmodule

// File: tb/tb_forward_unit_alu.sv
// Self-checking bench for forward_unit_alu: directed hazard cases plus randomized
// traffic compared against a register-scoreboard reference model.
module tb_forward_unit_alu;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] R2res3, R3res3, Res, Res1;
  logic [REG_W-1:0]  R2_2, R3_2, DestR_3, DestR_4;
  logic [1:0]        ExtndSel1;
  logic              immF;
  logic [DATA_W-1:0] R2res4, R3res4;

  int n_tests;
  int n_fail;

  forward_unit_alu #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .R2res3(R2res3), .R3res3(R3res3), .R2_2(R2_2), .R3_2(R3_2),
    .ExtndSel1(ExtndSel1), .immF(immF),
    .DestR_3(DestR_3), .Res(Res), .DestR_4(DestR_4), .Res1(Res1),
    .R2res4(R2res4), .R3res4(R3res4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: replay in-flight writes oldest first into a register map, so
  // the youngest writer of an index is what remains; unmapped indices read the RF.
  function automatic logic [DATA_W-1:0] lookup(input logic [REG_W-1:0] idx,
                                               input logic [DATA_W-1:0] rf_val);
    logic [DATA_W-1:0] inflight [int];
    inflight[int'(DestR_4)] = Res1;
    inflight[int'(DestR_3)] = Res;
    if (inflight.exists(int'(idx))) return inflight[int'(idx)];
    return rf_val;
  endfunction

  function automatic logic [DATA_W-1:0] model_a();
    return lookup(R2_2, R2res3);
  endfunction

  function automatic logic [DATA_W-1:0] model_b();
    if (immF) return R3res3;
    return lookup(R3_2, R3res3);
  endfunction

  task automatic drive(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [REG_W-1:0] ia, input logic [REG_W-1:0] ib,
                       input logic [1:0] ext, input logic imm,
                       input logic [REG_W-1:0] d3, input logic [DATA_W-1:0] r3,
                       input logic [REG_W-1:0] d4, input logic [DATA_W-1:0] r4);
    R2res3 = a; R3res3 = b; R2_2 = ia; R3_2 = ib; ExtndSel1 = ext; immF = imm;
    DestR_3 = d3; Res = r3; DestR_4 = d4; Res1 = r4;
  endtask

  // Captures expectations from the inputs present at the edge, then samples after it.
  task automatic tick_check(input string tag);
    logic [DATA_W-1:0] ea, eb;
    ea = model_a();
    eb = model_b();
    @(posedge clk);
    #1;
    check({tag, "_A"}, R2res4, ea);
    check({tag, "_B"}, R3res4, eb);
  endtask

  task automatic tick_const(input string tag, input logic [DATA_W-1:0] ea,
                            input logic [DATA_W-1:0] eb);
    @(posedge clk);
    #1;
    check({tag, "_A"}, R2res4, ea);
    check({tag, "_B"}, R3res4, eb);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    drive(32'h10, 32'h564, 4'd5, 4'd6, 2'd0, 1'b0, 4'd5, 32'h15, 4'd5, 32'h16);

    // Reset holds outputs at zero across edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_A", R2res4, '0);
    check("rst_hold_B", R3res4, '0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    tick_const("c1_s3_prio_a", 32'h15, 32'h564);
    @(negedge clk);
    DestR_3 = 4'd4;
    tick_const("c2_s4_fwd_a", 32'h16, 32'h564);
    @(negedge clk);
    drive(32'h10, 32'h11, 4'd5, 4'd6, 2'd0, 1'b0, 4'd6, 32'h15, 4'd6, 32'h16);
    tick_const("c3_s3_prio_b", 32'h10, 32'h15);
    @(negedge clk);
    drive(32'h10, 32'h11, 4'd5, 4'd6, 2'b10, 1'b1, 4'd6, 32'h15, 4'd6, 32'h16);
    tick_const("c4_imm_b", 32'h10, 32'h11);
    @(negedge clk);
    drive(32'hAAAA_0001, 32'hBBBB_0002, 4'd7, 4'd7, 2'd1, 1'b0, 4'd2, 32'h15, 4'd3, 32'h16);
    tick_const("c5_nohaz", 32'hAAAA_0001, 32'hBBBB_0002);
    @(negedge clk);
    DestR_3 = 4'd7;
    tick_const("c5_double", 32'h15, 32'h15);
    @(negedge clk);
    drive(32'h1, 32'h2, 4'd0, 4'd0, 2'd3, 1'b0, 4'd9, 32'hDEAD_BEEF, 4'd0, 32'hCAFE_F00D);
    tick_const("c_reg0_s4", 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Asynchronous reset between edges.
    @(negedge clk);
    drive(32'h10, 32'h564, 4'd5, 4'd6, 2'd0, 1'b0, 4'd5, 32'h15, 4'd5, 32'h16);
    tick_const("c6_load", 32'h15, 32'h564);
    #2;
    rst = 1'b0;
    #1;
    check("c6_async_A", R2res4, '0);
    check("c6_async_B", R3res4, '0);
    @(negedge clk);
    rst = 1'b1;
    DestR_3 = 4'd4;
    tick_const("c6_release", 32'h16, 32'h564);

    // Randomized traffic; narrow index range so hazards are frequent.
    for (int i = 0; i < 300; i++) begin
      logic [REG_W-1:0] rmax;
      @(negedge clk);
      rmax = (i % 2 == 0) ? 4'd3 : 4'd15;
      drive($urandom, $urandom,
            REG_W'($urandom_range(0, int'(rmax))), REG_W'($urandom_range(0, int'(rmax))),
            2'($urandom), 1'($urandom_range(0, 3) == 0),
            REG_W'($urandom_range(0, int'(rmax))), $urandom,
            REG_W'($urandom_range(0, int'(rmax))), $urandom);
      tick_check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
